// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory sequencer: memory op encoding,
// sequencer state encoding and small op-classification helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LDW  = 3'd1,
        OP_LDB  = 3'd2,
        OP_STW  = 3'd3,
        OP_STB  = 3'd4,
        OP_LDI  = 3'd5,
        OP_STI  = 3'd6
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // Encoding 3'd7 is unused; it is treated like NONE so it can never hang the pipe.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic logic op_is_byte(input mem_op_t op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    function automatic logic op_is_indirect(input mem_op_t op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte-lane steering for the data port: byte enables, store data replication
// and the zero-extended LDB byte select. Purely combinational.
module mem_access_ctrl_byte_lane #(
    parameter int WIDTH = 16
) (
    input  logic             byte_acc_i,
    input  logic             acc_lsb_i,
    input  logic [WIDTH-1:0] src_i,
    input  logic [WIDTH-1:0] rword_i,
    input  logic             rd_lsb_i,
    output logic [1:0]       mbe_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] ldb_o
);

    // Word accesses use both lanes; byte accesses pick the lane from address bit 0.
    always_comb begin
        mbe_o   = 2'b11;
        wdata_o = src_i;
        if (byte_acc_i) begin
            mbe_o   = acc_lsb_i ? 2'b10 : 2'b01;
            wdata_o = {(WIDTH/8){src_i[7:0]}};
        end
        ldb_o = {{(WIDTH-8){1'b0}}, (rd_lsb_i ? rword_i[15:8] : rword_i[7:0])};
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer for the LC-3b pipeline.
// Runs LDR/LDB/STR/STB and indirect LDI/STI against a handshaked data port and
// stalls the pipeline while an access is outstanding.
// Optional build macro: MEM_STALL_CNT_EN adds a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | waiting for a valid non-NONE request from EX/MEM
// ACC1  | first access at latched addr (pointer read for LDI/STI)
// ACC2  | second access at pointer (LDI read / STI write)
// DONE  | results valid for one cycle, pipeline advances
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [2:0]             req_op,
    input  logic [WIDTH-1:0]       req_addr,
    input  logic [WIDTH-1:0]       req_wdata,
    output logic                   stall_out,
    output logic                   done,
    output logic [WIDTH-1:0]       rdata_out,
    output logic [WIDTH-1:0]       ldb_shift_out,
    output logic [WIDTH-1:0]       addr_out,
    output logic                   d_read,
    output logic                   d_write,
    output logic [1:0]             d_mbe,
    output logic [WIDTH-1:0]       d_addr,
    output logic [WIDTH-1:0]       d_wdata,
    input  logic [WIDTH-1:0]       d_rdata,
    input  logic                   d_resp,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    mem_state_t       state_q;
    mem_op_t          op_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] addr_out_q;

    logic             byte_acc;
    logic [WIDTH-1:0] acc_addr;
    logic [1:0]       lane_mbe;
    logic [WIDTH-1:0] lane_wdata;

    // Sequencer: latch the request, walk the one or two accesses, pulse DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            ptr_q      <= '0;
            rdata_q    <= '0;
            addr_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && op_is_valid(req_op)) begin
                        op_q    <= mem_op_t'(req_op);
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= ST_ACC1;
                    end
                end
                ST_ACC1: begin
                    if (d_resp) begin
                        if (op_is_indirect(op_q)) begin
                            ptr_q   <= d_rdata;
                            state_q <= ST_ACC2;
                        end else begin
                            if ((op_q == OP_LDW) || (op_q == OP_LDB)) begin
                                rdata_q <= d_rdata;
                            end
                            addr_out_q <= addr_q;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_ACC2: begin
                    if (d_resp) begin
                        if (op_q == OP_LDI) begin
                            rdata_q <= d_rdata;
                        end
                        addr_out_q <= ptr_q;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe decode depends only on state and latched request, never on req_* or d_resp.
    always_comb begin
        d_read   = 1'b0;
        d_write  = 1'b0;
        byte_acc = 1'b0;
        acc_addr = addr_q;
        case (state_q)
            ST_ACC1: begin
                byte_acc = op_is_byte(op_q);
                d_read   = (op_q == OP_LDW) || (op_q == OP_LDB) || op_is_indirect(op_q);
                d_write  = (op_q == OP_STW) || (op_q == OP_STB);
            end
            ST_ACC2: begin
                acc_addr = ptr_q;
                d_read   = (op_q == OP_LDI);
                d_write  = (op_q == OP_STI);
            end
            default: ;
        endcase
        d_addr  = (d_read || d_write) ? {acc_addr[WIDTH-1:1], 1'b0} : '0;
        d_mbe   = (d_read || d_write) ? lane_mbe : 2'b00;
        d_wdata = d_write ? lane_wdata : '0;
    end

    mem_access_ctrl_byte_lane #(.WIDTH(WIDTH)) u_byte_lane (
        .byte_acc_i (byte_acc),
        .acc_lsb_i  (addr_q[0]),
        .src_i      (wdata_q),
        .rword_i    (rdata_q),
        .rd_lsb_i   (addr_out_q[0]),
        .mbe_o      (lane_mbe),
        .wdata_o    (lane_wdata),
        .ldb_o      (ldb_shift_out)
    );

    // Stall covers the accept cycle plus every access cycle; forced low while in reset.
    assign stall_out = !reset && (((state_q == ST_IDLE) && req_valid && op_is_valid(req_op))
                                  || (state_q == ST_ACC1) || (state_q == ST_ACC2));
    assign done      = (state_q == ST_DONE);
    assign rdata_out = rdata_q;
    assign addr_out  = addr_out_q;

`ifdef MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
